// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache port arbiter.
// Provides FSM state encoding, port indices, bus widths and the cache request payload.
package cache_arb_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF   = 16;

  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    WAIT  = 2'd3
  } state_e;

  // One cache access as seen on the cache input registers.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cache_req_t;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester-side req/done handshake bundle.
// master: requester drives req/wr/addr/wdata, receives done/rdata.
// slave : arbiter receives the request, drives done/rdata.
interface cache_port_arbiter_if;
  import cache_arb_pkg::*;

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, addr, wdata, input done, rdata);
  modport slave  (input req, wr, addr, wdata, output done, rdata);
endinterface

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick.
// Ports: req[1:0] requests, last_grant index of the previous tie winner,
//        grant[1:0] one-hot winner (all zero when nothing requests).
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache_4way port between instruction fetch (p0) and data (p1).
// Ports: clk/rst_n; p0/p1 requester handshakes; cache_data/addr/wr registered
//        to the cache; cache_response/miss/out from the cache; saturating
//        read hit/miss counters; sticky timeout_err.
// The cache only starts work when its inputs change, so identical reads are
// forced to differ by inverting the (don't-care) data word, and identical
// writes are completed locally.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_port_arbiter_if.slave p0,
  cache_port_arbiter_if.slave p1,
  output logic [DATA_W-1:0]   cache_data,
  output logic [ADDR_W-1:0]   cache_addr,
  output logic                cache_wr,
  input  logic                cache_response,
  input  logic                cache_miss,
  input  logic [DATA_W-1:0]   cache_out,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt,
  output logic                timeout_err
);

  localparam int unsigned WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    gnt_q, gnt_d;
  cache_req_t              cur_q, cur_d;
  cache_req_t              cache_q, cache_d;
  logic [1:0]              done_q, done_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]        hit_q, hit_d, miss_q, miss_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic                    terr_q, terr_d;

  logic [1:0]              req, grant;
  cache_req_t              win;
  logic                    same;
  logic                    complete, tmo;

  assign req = {p1.req, p0.req};

  rr_arbiter_2 u_rr (
    .req        (req),
    .last_grant (last_q),
    .grant      (grant)
  );

  // Winning request and whether the cache would see it as unchanged.
  assign win  = grant[P1] ? cache_req_t'{wr: p1.wr, addr: p1.addr, data: p1.wdata}
                          : cache_req_t'{wr: p0.wr, addr: p0.addr, data: p0.wdata};
  assign same = (win == cache_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    cur_d    = cur_q;
    cache_d  = cache_q;
    done_d   = 2'b00;
    rdata_d  = rdata_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    wcnt_d   = wcnt_q;
    terr_d   = terr_q;
    complete = 1'b0;
    tmo      = 1'b0;

    case (state_q)
      IDLE: begin
        // A done pulse in flight blocks arbitration so requesters can drop req.
        if (grant != 2'b00 && done_q == 2'b00) begin
          gnt_d = grant[P1];
          if (req == 2'b11) last_d = grant[P1];
          if (same && win.wr) begin
            done_d[grant[P1]] = 1'b1;
          end else begin
            cur_d = win;
            if (same) cur_d.data = ~cache_q.data;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cache_d = cur_q;
        state_d = CHECK;
      end
      CHECK: begin
        if (!cur_q.wr) begin
          if (cache_miss) begin
            if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
          end else begin
            if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
          end
        end
        if (cache_response) begin
          complete = 1'b1;
        end else begin
          wcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cache_response) begin
          complete = 1'b1;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          complete = 1'b1;
          tmo      = 1'b1;
          terr_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion: pulse done, return read data (zero on timeout).
    if (complete) begin
      done_d[gnt_q] = 1'b1;
      if (!cur_q.wr) rdata_d[gnt_q] = tmo ? '0 : cache_out;
      state_d = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cur_q   <= '0;
      cache_q <= '0;
      done_q  <= 2'b00;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      wcnt_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cur_q   <= cur_d;
      cache_q <= cache_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      wcnt_q  <= wcnt_d;
      terr_q  <= terr_d;
    end
  end

  assign p0.done     = done_q[P0];
  assign p1.done     = done_q[P1];
  assign p0.rdata    = rdata_q[P0];
  assign p1.rdata    = rdata_q[P1];
  assign cache_data  = cache_q.data;
  assign cache_addr  = cache_q.addr;
  assign cache_wr    = cache_q.wr;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed self-checking bench for cache_port_arbiter.
// The cache is modelled by directly driving response/miss/out per step.
module tb_cache_port_arbiter;
  import cache_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] cache_data, cache_addr;
  logic        cache_wr;
  logic        cache_response, cache_miss;
  logic [31:0] cache_out;
  logic [15:0] hit_cnt, miss_cnt;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  cache_port_arbiter_if p0_if ();
  cache_port_arbiter_if p1_if ();

  cache_port_arbiter #(.TIMEOUT(64), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p0             (p0_if),
    .p1             (p1_if),
    .cache_data     (cache_data),
    .cache_addr     (cache_addr),
    .cache_wr       (cache_wr),
    .cache_response (cache_response),
    .cache_miss     (cache_miss),
    .cache_out      (cache_out),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
    if (port == 0) begin
      p0_if.req = 1'b1; p0_if.wr = wr; p0_if.addr = addr; p0_if.wdata = data;
    end else begin
      p1_if.req = 1'b1; p1_if.wr = wr; p1_if.addr = addr; p1_if.wdata = data;
    end
  endtask

  task automatic drop(input int port);
    if (port == 0) p0_if.req = 1'b0;
    else           p1_if.req = 1'b0;
  endtask

  // Step until some done pulse is visible; an exhausted bound is a failure.
  task automatic wait_any(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(p0_if.done || p1_if.done) && n < bound);
    chk("wait_bound", 32'((p0_if.done || p1_if.done) ? 1 : 0), 32'd1);
  endtask

  int n;
  int pidx;

  initial begin
    rst_n = 1'b0;
    p0_if.req = 1'b0; p0_if.wr = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
    p1_if.req = 1'b0; p1_if.wr = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;
    cache_response = 1'b0; cache_miss = 1'b0; cache_out = '0;
    #3;
    chk("rst_p0_done",  32'(p0_if.done), 32'd0);
    chk("rst_p1_done",  32'(p1_if.done), 32'd0);
    chk("rst_p0_rdata", p0_if.rdata, 32'd0);
    chk("rst_cache_addr", cache_addr, 32'd0);
    chk("rst_cache_data", cache_data, 32'd0);
    chk("rst_cache_wr", 32'(cache_wr), 32'd0);
    chk("rst_hit",      32'(hit_cnt), 32'd0);
    chk("rst_miss",     32'(miss_cnt), 32'd0);
    chk("rst_terr",     32'(timeout_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // p0 read hit
    cache_response = 1'b1; cache_out = 32'hA5A5_A5A5;
    set_req(0, 1'b0, 32'h10, 32'h0);
    step();
    chk("hit_c1_done", 32'(p0_if.done), 32'd0);
    step();
    chk("hit_c2_done", 32'(p0_if.done), 32'd0);
    chk("hit_c2_addr", cache_addr, 32'h10);
    step();
    chk("hit_c3_done",  32'(p0_if.done), 32'd1);
    chk("hit_rdata",    p0_if.rdata, 32'hA5A5_A5A5);
    chk("hit_cnt1",     32'(hit_cnt), 32'd1);
    drop(0);
    step();
    chk("hit_pulse_end", 32'(p0_if.done), 32'd0);

    // tie arbitration: p0, p1, p0, p1
    set_req(0, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_any(20, n);
      chk("tie_lat",  32'(n), 32'd3);
      chk("tie_port", 32'(p1_if.done), 32'(i % 2));
      pidx = p1_if.done ? 1 : 0;
      drop(pidx);
      step();
      if (i < 2) set_req(pidx, 1'b0, (pidx == 1) ? 32'h204 : 32'h104, 32'h0);
    end
    chk("tie_hits", 32'(hit_cnt), 32'd5);

    // p1 read miss, response after 10 low cycles
    cache_response = 1'b0; cache_miss = 1'b1;
    set_req(1, 1'b0, 32'h300, 32'h0);
    step();
    step();
    for (int i = 0; i < 10; i++) step();
    chk("miss_cnt1",    32'(miss_cnt), 32'd1);
    chk("miss_nodone",  32'(p1_if.done), 32'd0);
    cache_response = 1'b1; cache_miss = 1'b0; cache_out = 32'h1234;
    step();
    chk("miss_done",    32'(p1_if.done), 32'd1);
    chk("miss_rdata",   p1_if.rdata, 32'h1234);
    chk("miss_hits",    32'(hit_cnt), 32'd5);
    drop(1);
    step();

    // write 0x20/0x55 then identical write completes locally
    set_req(0, 1'b1, 32'h20, 32'h55);
    wait_any(20, n);
    chk("wr_lat",   32'(n), 32'd3);
    chk("wr_cwr",   32'(cache_wr), 32'd1);
    chk("wr_caddr", cache_addr, 32'h20);
    chk("wr_cdata", cache_data, 32'h55);
    drop(0);
    step();
    set_req(0, 1'b1, 32'h20, 32'h55);
    step();
    chk("same_wr_done",  32'(p0_if.done), 32'd1);
    chk("same_wr_caddr", cache_addr, 32'h20);
    chk("same_wr_cdata", cache_data, 32'h55);
    chk("same_wr_cwr",   32'(cache_wr), 32'd1);
    chk("same_wr_hit",   32'(hit_cnt), 32'd5);
    chk("same_wr_miss",  32'(miss_cnt), 32'd1);
    chk("same_wr_rdata", p0_if.rdata, 32'hA5A5_A5A5);
    drop(0);
    step();

    // read 0x20 twice; second forces inverted data
    cache_out = 32'hCAFE_0001;
    set_req(0, 1'b0, 32'h20, 32'h55);
    wait_any(20, n);
    chk("rd1_lat",   32'(n), 32'd3);
    chk("rd1_rdata", p0_if.rdata, 32'hCAFE_0001);
    chk("rd1_cdata", cache_data, 32'h55);
    chk("rd1_cwr",   32'(cache_wr), 32'd0);
    drop(0);
    step();
    cache_out = 32'hCAFE_0002;
    set_req(0, 1'b0, 32'h20, 32'h55);
    wait_any(20, n);
    chk("rd2_lat",   32'(n), 32'd3);
    chk("rd2_cdata", cache_data, 32'hFFFF_FFAA);
    chk("rd2_rdata", p0_if.rdata, 32'hCAFE_0002);
    chk("rd2_hits",  32'(hit_cnt), 32'd7);
    drop(0);
    step();

    // p1 read timeout
    cache_response = 1'b0; cache_miss = 1'b0;
    set_req(1, 1'b0, 32'h400, 32'h0);
    wait_any(200, n);
    chk("tmo_lat",   32'(n), 32'd67);
    chk("tmo_done",  32'(p1_if.done), 32'd1);
    chk("tmo_rdata", p1_if.rdata, 32'd0);
    chk("tmo_err",   32'(timeout_err), 32'd1);
    chk("tmo_hits",  32'(hit_cnt), 32'd8);
    drop(1);
    step();
    chk("tmo_sticky", 32'(timeout_err), 32'd1);

    // reset asserted mid-WAIT
    set_req(0, 1'b0, 32'h500, 32'h0);
    for (int i = 0; i < 12; i++) step();
    chk("mid_nodone", 32'(p0_if.done), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_terr",   32'(timeout_err), 32'd0);
    chk("arst_hit",    32'(hit_cnt), 32'd0);
    chk("arst_miss",   32'(miss_cnt), 32'd0);
    chk("arst_caddr",  cache_addr, 32'd0);
    chk("arst_cdata",  cache_data, 32'd0);
    chk("arst_p0rd",   p0_if.rdata, 32'd0);
    chk("arst_p0done", 32'(p0_if.done), 32'd0);
    drop(0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares one cache_4way port between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Converts each requester's req/done handshake into the cache's change-triggered protocol. The cache starts a transaction only when data/addr/wr differ from the last values it sampled, and signals completion on response.
- Round-robin arbitration, read hit/miss counters, and a sticky timeout error for a RAM that never responds.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before forced completion.
- CNT_W, 16, width of the hit and miss counters (saturating).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- p0_req  in  1  port 0 request; held with p0_wr/p0_addr/p0_wdata stable until p0_done
- p0_wr  in  1  1 = write, 0 = read
- p0_addr  in  32  byte address
- p0_wdata  in  32  write data
- p0_done  out  1  one-cycle completion pulse
- p0_rdata  out  32  read data; updated on read completion, held otherwise
- p1_req, p1_wr, p1_addr, p1_wdata, p1_done, p1_rdata: same as port 0
- cache_data  out  32  registered, to cache data
- cache_addr  out  32  registered, to cache addr
- cache_wr  out  1  registered, to cache wr
- cache_response  in  1  cache done flag
- cache_miss  in  1  cache is_missrate
- cache_out  in  32  cache read data
- hit_cnt  out  CNT_W  read hits
- miss_cnt  out  CNT_W  read misses
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so port 0 wins the first tie; wait counter 0.
  - cache_* reset to 0 because these equal the cache's power-up input registers.
- IDLE:
  - Neither request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant !last_grant, then set last_grant to the winner.
  - Latch the winner's wr/addr/wdata into the cur_* registers and go to ISSUE.
- Same-request rule, applied in IDLE when the granted request equals the current cache_{wr,addr,data}:
  - Write: it is idempotent, so complete locally. Pulse done next cycle, no cache access, no counter change, return to IDLE.
  - Read: drive cache_data = ~cache_data (data is don't-care on reads) so the cache sees a change and re-reads.
- ISSUE (1 cycle): cache_* take the new values at this edge; go to CHECK.
- CHECK: the cache has sampled the inputs at the preceding edge, so cache_response and cache_miss are valid.
  - Read: sample cache_miss, increment hit_cnt or miss_cnt (saturate at all-ones).
  - cache_response = 1: complete.
  - Otherwise: go to WAIT with the counter cleared.
- WAIT:
  - Each cycle, if cache_response = 1, complete.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no response, set timeout_err and complete with rdata = 0.
- Complete:
  - Pulse the granted port's done for exactly one cycle, registered.
  - Read: rdata <= cache_out (or 0 on timeout).
  - Write: rdata unchanged.
  - Go to IDLE.
- The next grant is evaluated in the cycle after done, so one IDLE cycle minimum sits between transactions.
- Latency:
  - Read hit: req to done = 3 cycles (IDLE, ISSUE, CHECK).
  - Local same-write: 1 cycle.
- Requests that drop before done: ignored. The transaction completes and the done pulse is still emitted.
- Non-granted port requests are held off, with no done, until their grant.
- Reset mid-transaction: immediate return to reset values; an in-flight cache/RAM access is abandoned.
- Counters are never wrapped.

Decomposition:
- Shared header/package cache_arb_pkg:
  - state encodings IDLE=0, ISSUE=1, CHECK=2, WAIT=3
  - port indices P0=0, P1=1
- One sub-module, rr_arbiter_2: combinational 2-way round-robin pick from req[1:0] and last_grant, producing a one-hot grant.

Test Plan:
- Reset, then p0 read addr 0x10 with the cache model hitting (response=1, out=0xA5A5A5A5) -> p0_done on the 3rd cycle, p0_rdata=0xA5A5A5A5, hit_cnt=1.
- p0 and p1 request in the same cycle, then again -> order p0, p1, p0, p1; no port granted twice while the other waits.
- p1 read with a miss, cache_response low 10 cycles then high with out=0x1234 -> miss_cnt=1, p1_done one cycle after response rises, rdata=0x1234.
- Repeated identical write (addr 0x20, data 0x55) -> second one: p0_done one cycle after IDLE, cache_* unchanged, counters unchanged.
- Repeated identical read of 0x20 -> cache_data driven to ~previous, cache re-transacts, correct rdata.
- Read with cache_response stuck low -> done after TIMEOUT cycles in WAIT, rdata=0, timeout_err=1 until rst_n asserted; rst_n low mid-WAIT -> all outputs 0 asynchronously.
